// File: rtl/pipe_fwd_chain.sv
// ---------------------------------------------------------------------------
// pipe_fwd_chain
//   In-order pipeline of DEPTH result-carrying stages with operand forwarding.
//   Each stage holds {valid, regwr, wsel, data, data_ok}. Entries shift one
//   stage per unstalled clock, can be squashed per stage, and can have a late
//   result (load data) written into them while in flight. NQ query channels
//   look up the youngest in-flight writer of a register and return its value,
//   or flag that the value is still pending.
//
// Ports
//   CLK, nRST                clock; asynchronous active-high reset
//   in_valid/in_regwr/in_wsel/in_data/in_data_ok   new entry for stage 0
//   stall                    hold every stage, ignore in_*
//   flush_mask[DEPTH]        squash the entry in stage k
//   upd_en/upd_stage/upd_data   late result into one stage
//   q_sel[NQ*RW]             per-channel source register index
//   q_hit/q_data/q_wait      per-channel forwarding result
//   out_valid/out_wsel/out_data   writeback from the last stage
//   occ                      registered count of valid stages
// ---------------------------------------------------------------------------
module pipe_fwd_chain #(
    parameter int DEPTH = 3,
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int NQ    = 2
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       in_valid,
    input  logic                       in_regwr,
    input  logic [RW-1:0]              in_wsel,
    input  logic [DW-1:0]              in_data,
    input  logic                       in_data_ok,
    input  logic                       stall,
    input  logic [DEPTH-1:0]           flush_mask,
    input  logic                       upd_en,
    input  logic [$clog2(DEPTH)-1:0]   upd_stage,
    input  logic [DW-1:0]              upd_data,
    input  logic [NQ*RW-1:0]           q_sel,
    output logic [NQ-1:0]              q_hit,
    output logic [NQ*DW-1:0]           q_data,
    output logic [NQ-1:0]              q_wait,
    output logic                       out_valid,
    output logic [RW-1:0]              out_wsel,
    output logic [DW-1:0]              out_data,
    output logic [$clog2(DEPTH+1)-1:0] occ
);
    localparam int SW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_reg, regwr_reg, data_ok_reg;
    logic [RW-1:0]    wsel_reg [DEPTH];
    logic [DW-1:0]    data_reg [DEPTH];

    logic [DEPTH-1:0] valid_next, regwr_next, data_ok_next;
    logic [RW-1:0]    wsel_next [DEPTH];
    logic [DW-1:0]    data_next [DEPTH];

    // Stage contents after this cycle's squash and late-result update, before
    // the shift. Squash wins over update simply because eff_valid drops.
    logic [DEPTH-1:0] eff_valid, eff_ok;
    logic [DW-1:0]    eff_data [DEPTH];

    logic [OW-1:0]    occ_reg, occ_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic upd_hit;
            // Updates to an empty stage are dropped here.
            assign upd_hit        = upd_en && (upd_stage == SW'(gi)) && valid_reg[gi];
            assign eff_valid[gi]  = valid_reg[gi] & ~flush_mask[gi];
            assign eff_ok[gi]     = data_ok_reg[gi] | upd_hit;
            assign eff_data[gi]   = upd_hit ? upd_data : data_reg[gi];

            if (gi == 0) begin : g_head
                assign valid_next[gi]   = stall ? eff_valid[gi]  : in_valid;
                assign regwr_next[gi]   = stall ? regwr_reg[gi]  : in_regwr;
                assign wsel_next[gi]    = stall ? wsel_reg[gi]   : in_wsel;
                assign data_next[gi]    = stall ? eff_data[gi]   : in_data;
                assign data_ok_next[gi] = stall ? eff_ok[gi]     : in_data_ok;
            end else begin : g_body
                assign valid_next[gi]   = stall ? eff_valid[gi]  : eff_valid[gi-1];
                assign regwr_next[gi]   = stall ? regwr_reg[gi]  : regwr_reg[gi-1];
                assign wsel_next[gi]    = stall ? wsel_reg[gi]   : wsel_reg[gi-1];
                assign data_next[gi]    = stall ? eff_data[gi]   : eff_data[gi-1];
                assign data_ok_next[gi] = stall ? eff_ok[gi]     : eff_ok[gi-1];
            end
        end
    endgenerate

    // Occupancy is counted from the next-state valid bits so the registered
    // count lines up with the stage registers on the same edge.
    always_comb begin
        occ_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_next = occ_next + OW'(valid_next[i]);
        end
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            valid_reg   <= '0;
            regwr_reg   <= '0;
            data_ok_reg <= '0;
            occ_reg     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                wsel_reg[i] <= '0;
                data_reg[i] <= '0;
            end
        end else begin
            valid_reg   <= valid_next;
            regwr_reg   <= regwr_next;
            data_ok_reg <= data_ok_next;
            occ_reg     <= occ_next;
            for (int i = 0; i < DEPTH; i++) begin
                wsel_reg[i] <= wsel_next[i];
                data_reg[i] <= data_next[i];
            end
        end
    end

    assign occ = occ_reg;

    // Forwarding lookup on registered state only. Scanning from the oldest
    // stage down lets the youngest match overwrite older ones.
    generate
        for (gi = 0; gi < NQ; gi++) begin : g_query
            logic [RW-1:0] sel;
            logic          hit;
            logic          ok;
            logic [DW-1:0] dat;

            always_comb begin
                sel = q_sel[gi*RW +: RW];
                hit = 1'b0;
                ok  = 1'b0;
                dat = '0;
                for (int k = DEPTH-1; k >= 0; k--) begin
                    if (valid_reg[k] && regwr_reg[k] && (wsel_reg[k] == sel)) begin
                        hit = 1'b1;
                        ok  = data_ok_reg[k];
                        dat = data_reg[k];
                    end
                end
                // Register 0 is never forwarded.
                if (sel == '0) begin
                    hit = 1'b0;
                end
            end

            assign q_hit[gi]             = hit;
            assign q_wait[gi]            = hit & ~ok;
            assign q_data[gi*DW +: DW]   = (hit && ok) ? dat : '0;
        end
    endgenerate

    // A pending-load entry (data_ok=0) reaching the end retires silently.
    assign out_valid = valid_reg[DEPTH-1] & regwr_reg[DEPTH-1] & data_ok_reg[DEPTH-1]
                     & ~stall & ~flush_mask[DEPTH-1];
    assign out_wsel  = wsel_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];

endmodule

// File: tb/tb_pipe_fwd_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_fwd_chain
//   Directed bench for pipe_fwd_chain (DEPTH=3, DW=32, RW=5, NQ=2).
//   Expected writebacks {wsel, data, cycle} are queued when an entry is
//   issued and popped by a negedge monitor whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_pipe_fwd_chain;
    localparam int DEPTH = 3;
    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int NQ    = 2;

    logic                       CLK;
    logic                       nRST;
    logic                       in_valid, in_regwr, in_data_ok;
    logic [RW-1:0]              in_wsel;
    logic [DW-1:0]              in_data;
    logic                       stall;
    logic [DEPTH-1:0]           flush_mask;
    logic                       upd_en;
    logic [$clog2(DEPTH)-1:0]   upd_stage;
    logic [DW-1:0]              upd_data;
    logic [NQ*RW-1:0]           q_sel;
    logic [NQ-1:0]              q_hit, q_wait;
    logic [NQ*DW-1:0]           q_data;
    logic                       out_valid;
    logic [RW-1:0]              out_wsel;
    logic [DW-1:0]              out_data;
    logic [$clog2(DEPTH+1)-1:0] occ;

    pipe_fwd_chain #(.DEPTH(DEPTH), .DW(DW), .RW(RW), .NQ(NQ)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_regwr(in_regwr), .in_wsel(in_wsel),
        .in_data(in_data), .in_data_ok(in_data_ok),
        .stall(stall), .flush_mask(flush_mask),
        .upd_en(upd_en), .upd_stage(upd_stage), .upd_data(upd_data),
        .q_sel(q_sel), .q_hit(q_hit), .q_data(q_data), .q_wait(q_wait),
        .out_valid(out_valid), .out_wsel(out_wsel), .out_data(out_data),
        .occ(occ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic [RW-1:0] wsel;
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } wb_t;
    wb_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_q(input string tag, input int n, input logic h,
                         input logic [DW-1:0] d, input logic w);
        chk({tag, "_hit"},  64'(q_hit[n]),          64'(h));
        chk({tag, "_data"}, 64'(q_data[n*DW +: DW]), 64'(d));
        chk({tag, "_wait"}, 64'(q_wait[n]),         64'(w));
        $display("query %s ch%0d: hit=%0d data=%0h wait=%0d", tag, n,
                 q_hit[n], q_data[n*DW +: DW], q_wait[n]);
    endtask

    // Scoreboard monitor: sampled mid-cycle, when inputs for this cycle are stable.
    always @(negedge CLK) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", 64'(out_valid), 64'd0);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_wsel", 64'(out_wsel), 64'(e.wsel));
                chk("wb_data", 64'(out_data), 64'(e.data));
                chk("wb_cycle", 64'(cyc), 64'(e.cyc));
                $display("writeback cyc=%0d r%0d=%0h (expected r%0d=%0h at cyc %0d)",
                         cyc, out_wsel, out_data, e.wsel, e.data, e.cyc);
            end
        end
    end

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_regwr   = 1'b0;
        in_wsel    = '0;
        in_data    = '0;
        in_data_ok = 1'b0;
        stall      = 1'b0;
        flush_mask = '0;
        upd_en     = 1'b0;
        upd_stage  = '0;
        upd_data   = '0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
        idle_inputs();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [RW-1:0] w, input logic [DW-1:0] d,
                         input logic ok, input logic rw);
        in_valid   = 1'b1;
        in_wsel    = w;
        in_data    = d;
        in_data_ok = ok;
        in_regwr   = rw;
    endtask

    task automatic expect_wb(input logic [RW-1:0] w, input logic [DW-1:0] d, input int at);
        sb.push_back('{wsel: w, data: d, cyc: 32'(at)});
    endtask

    initial begin
        nRST = 1'b1;
        idle_inputs();
        q_sel = '0;

        // Reset state, with an entry offered that must not load.
        repeat (2) @(posedge CLK);
        #1;
        issue(5'd5, 32'h55, 1'b1, 1'b1);
        q_sel = {5'd0, 5'd5};
        settle();
        chk("reset_occ", 64'(occ), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk_q("reset_q", 0, 1'b0, 32'h0, 1'b0);
        idle_inputs();
        @(negedge CLK);
        nRST = 1'b0;

        // Back-to-back writers of r5; youngest forwards; fixed latency.
        next_cycle();
        issue(5'd5, 32'h11, 1'b1, 1'b1);
        expect_wb(5'd5, 32'h11, cyc + 3);
        q_sel = {5'd6, 5'd5};
        settle();
        chk_q("same_cycle_invisible", 0, 1'b0, 32'h0, 1'b0);
        chk("t1_occ0", 64'(occ), 64'd0);
        next_cycle();
        issue(5'd5, 32'h22, 1'b1, 1'b1);
        expect_wb(5'd5, 32'h22, cyc + 3);
        settle();
        chk_q("r5_first", 0, 1'b1, 32'h11, 1'b0);
        next_cycle();
        settle();
        chk_q("r5_youngest", 0, 1'b1, 32'h22, 1'b0);
        chk_q("r6_miss", 1, 1'b0, 32'h0, 1'b0);
        chk("t1_occ2", 64'(occ), 64'd2);
        next_cycle();
        settle();
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        next_cycle();
        next_cycle();
        settle();
        chk("t1_drained_occ", 64'(occ), 64'd0);

        // Load with late result.
        next_cycle();
        issue(5'd7, 32'hDEAD, 1'b0, 1'b1);
        expect_wb(5'd7, 32'hABCD, cyc + 3);
        q_sel = {5'd0, 5'd7};
        next_cycle();
        settle();
        chk_q("load_wait", 0, 1'b1, 32'h0, 1'b1);
        next_cycle();
        upd_en    = 1'b1;
        upd_stage = 2'd1;
        upd_data  = 32'hABCD;
        settle();
        chk_q("upd_same_cycle", 0, 1'b1, 32'h0, 1'b1);
        next_cycle();
        settle();
        chk_q("upd_fwd", 0, 1'b1, 32'hABCD, 1'b0);
        chk("t2_out_valid", 64'(out_valid), 64'd1);
        next_cycle();
        settle();
        chk("t2_occ", 64'(occ), 64'd0);

        // Two stall cycles on a full pipe; order preserved after release.
        next_cycle();
        issue(5'd1, 32'h101, 1'b1, 1'b1);
        expect_wb(5'd1, 32'h101, cyc + 5);
        next_cycle();
        issue(5'd2, 32'h202, 1'b1, 1'b1);
        expect_wb(5'd2, 32'h202, cyc + 5);
        next_cycle();
        issue(5'd3, 32'h303, 1'b1, 1'b1);
        expect_wb(5'd3, 32'h303, cyc + 5);
        for (int s = 0; s < 2; s++) begin
            next_cycle();
            stall = 1'b1;
            issue(5'd9, 32'h999, 1'b1, 1'b1);
            q_sel = {5'd9, 5'd1};
            settle();
            chk("stall_occ", 64'(occ), 64'd3);
            chk("stall_out_valid", 64'(out_valid), 64'd0);
            chk_q("stall_r1", 0, 1'b1, 32'h101, 1'b0);
        end
        next_cycle();
        settle();
        chk("release_occ", 64'(occ), 64'd3);
        chk_q("stall_in_ignored", 1, 1'b0, 32'h0, 1'b0);
        chk("release_out_valid", 64'(out_valid), 64'd1);
        repeat (3) next_cycle();
        settle();
        chk("t3_occ", 64'(occ), 64'd0);

        // Flushes: shifting squash, squash beating update, in-place squash,
        // update to empty stage, and suppressed retirement.
        next_cycle();
        issue(5'd10, 32'hA, 1'b1, 1'b1);
        expect_wb(5'd10, 32'hA, cyc + 3);
        next_cycle();
        issue(5'd11, 32'hB, 1'b1, 1'b1);
        next_cycle();
        issue(5'd12, 32'hC, 1'b1, 1'b1);
        next_cycle();
        flush_mask = 3'b011;
        upd_en     = 1'b1;
        upd_stage  = 2'd0;
        upd_data   = 32'h77;
        issue(5'd13, 32'hD, 1'b1, 1'b1);
        settle();
        chk("pre_flush_occ", 64'(occ), 64'd3);
        chk("flush_keeps_s2_wb", 64'(out_valid), 64'd1);
        next_cycle();
        issue(5'd14, 32'hE, 1'b1, 1'b1);
        q_sel = {5'd11, 5'd12};
        settle();
        chk("flush_occ", 64'(occ), 64'd1);
        chk_q("flush_upd_squash", 0, 1'b0, 32'h0, 1'b0);
        chk_q("flush_s1", 1, 1'b0, 32'h0, 1'b0);
        next_cycle();
        stall      = 1'b1;
        flush_mask = 3'b001;
        issue(5'd15, 32'hF, 1'b1, 1'b1);
        q_sel = {5'd13, 5'd14};
        settle();
        chk("t4_occ2", 64'(occ), 64'd2);
        chk_q("pre_inplace_r14", 0, 1'b1, 32'hE, 1'b0);
        chk_q("r13", 1, 1'b1, 32'hD, 1'b0);
        next_cycle();
        upd_en    = 1'b1;
        upd_stage = 2'd0;
        upd_data  = 32'h55;
        q_sel = {5'd15, 5'd14};
        settle();
        chk("inplace_occ", 64'(occ), 64'd1);
        chk_q("inplace_flushed", 0, 1'b0, 32'h0, 1'b0);
        chk_q("stall_in15_ignored", 1, 1'b0, 32'h0, 1'b0);
        next_cycle();
        flush_mask = 3'b100;
        q_sel = {5'd0, 5'd13};
        settle();
        chk("upd_empty_occ", 64'(occ), 64'd1);
        chk_q("r13_s2", 0, 1'b1, 32'hD, 1'b0);
        chk("flush_last_no_wb", 64'(out_valid), 64'd0);
        next_cycle();
        settle();
        chk("t4_occ0", 64'(occ), 64'd0);

        // r0, pending load retire, regwr=0, reset mid-stream.
        next_cycle();
        issue(5'd0, 32'h99, 1'b1, 1'b1);
        expect_wb(5'd0, 32'h99, cyc + 3);
        next_cycle();
        issue(5'd4, 32'h44, 1'b0, 1'b1);
        q_sel = {5'd4, 5'd0};
        settle();
        chk_q("r0_nohit", 0, 1'b0, 32'h0, 1'b0);
        next_cycle();
        issue(5'd20, 32'h200, 1'b1, 1'b1);
        q_sel = {5'd20, 5'd4};
        settle();
        chk_q("load_r4_wait", 0, 1'b1, 32'h0, 1'b1);
        next_cycle();
        issue(5'd21, 32'h210, 1'b1, 1'b0);
        settle();
        chk_q("r20", 1, 1'b1, 32'h200, 1'b0);
        next_cycle();
        q_sel = {5'd20, 5'd21};
        settle();
        chk_q("regwr0_miss", 0, 1'b0, 32'h0, 1'b0);
        chk("pre_reset_occ", 64'(occ), 64'd3);
        chk("pending_load_no_wb", 64'(out_valid), 64'd0);
        nRST = 1'b1;
        settle();
        chk("async_reset_occ", 64'(occ), 64'd0);
        chk("async_reset_out_valid", 64'(out_valid), 64'd0);
        chk_q("async_reset_q", 1, 1'b0, 32'h0, 1'b0);
        next_cycle();
        issue(5'd22, 32'h222, 1'b1, 1'b1);
        expect_wb(5'd22, 32'h222, cyc + 3);
        settle();
        chk("in_reset_occ", 64'(occ), 64'd0);
        nRST = 1'b0;
        next_cycle();
        q_sel = {5'd0, 5'd22};
        settle();
        chk("post_reset_occ", 64'(occ), 64'd1);
        chk_q("post_reset_accept", 0, 1'b1, 32'h222, 1'b0);
        repeat (4) next_cycle();
        settle();
        chk("final_occ", 64'(occ), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
